// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The slave modport is the adder itself; master is the producer/consumer side.
interface cla_pipe_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder: stage 1 registers bit and nibble P/G,
// stage 2 resolves carries by two-level lookahead and registers sum/cout/ovf.
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    cla_pipe_adder_if.slave bus
);
    localparam int unsigned NG  = WIDTH / 4;
    localparam int unsigned NGP = ((NG + 3) / 4) * 4;
    localparam int unsigned NSG = NGP / 4;

    if ((WIDTH % 4 != 0) || (WIDTH < 8) || (WIDTH > 64)) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 in the range 8..64");
    end

    // Carries into bits 0..3 of a 4-bit lookahead unit.
    function automatic logic [3:0] carries4(input logic [3:0] p, input logic [3:0] g,
                                            input logic c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // Group {P, G} of a 4-bit lookahead unit.
    function automatic logic [1:0] group4(input logic [3:0] p, input logic [3:0] g);
        logic gg;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {&p, gg};
    endfunction

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NG-1:0]    s1_pg;
    logic [NG-1:0]    s1_gg;
    logic             s1_cin;
    logic             s1_amsb;
    logic             s1_bmsb;

    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic             s1_load;
    logic             s2_load;
    logic             in_ready;

    logic [WIDTH-1:0] in_p;
    logic [WIDTH-1:0] in_g;
    logic [NG-1:0]    in_pg;
    logic [NG-1:0]    in_gg;
    logic [1:0]       in_grp;

    logic [NGP-1:0]   pgx;
    logic [NGP-1:0]   ggx;
    logic [3:0]       spx;
    logic [3:0]       sgx;
    logic [1:0]       sgrp;
    logic [1:0]       top;
    logic [3:0]       sc;
    logic [3:0]       gct;
    logic [NGP-1:0]   gc;
    logic [3:0]       bct;
    logic [WIDTH-1:0] bc;
    logic [WIDTH-1:0] nxt_sum;
    logic             nxt_cout;
    logic             nxt_ovf;

    always_comb begin
        s2_load  = s1_valid && (!out_valid_r || bus.out_ready);
        in_ready = !s1_valid || s2_load;
        s1_load  = bus.in_valid && in_ready;
    end

    always_comb begin
        in_p   = bus.a ^ bus.b;
        in_g   = bus.a & bus.b;
        in_pg  = '0;
        in_gg  = '0;
        in_grp = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            in_grp   = group4(in_p[4*k +: 4], in_g[4*k +: 4]);
            in_pg[k] = in_grp[1];
            in_gg[k] = in_grp[0];
        end
    end

    // Unused group/super-group slots are padded as pure propagate so the carry
    // out of the last real group flows straight through to the top-level lookahead.
    always_comb begin
        pgx            = '1;
        ggx            = '0;
        pgx[NG-1:0]    = s1_pg;
        ggx[NG-1:0]    = s1_gg;
        spx            = '1;
        sgx            = '0;
        sgrp           = '0;
        for (int unsigned s = 0; s < NSG; s++) begin
            sgrp   = group4(pgx[4*s +: 4], ggx[4*s +: 4]);
            spx[s] = sgrp[1];
            sgx[s] = sgrp[0];
        end
        sc  = carries4(spx, sgx, s1_cin);
        top = group4(spx, sgx);
        gc  = '0;
        gct = '0;
        for (int unsigned s = 0; s < NSG; s++) begin
            gct           = carries4(pgx[4*s +: 4], ggx[4*s +: 4], sc[s]);
            gc[4*s +: 4]  = gct;
        end
        bc  = '0;
        bct = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            bct          = carries4(s1_p[4*k +: 4], s1_g[4*k +: 4], gc[k]);
            bc[4*k +: 4] = bct;
        end
        nxt_sum  = s1_p ^ bc;
        nxt_cout = top[0] | (top[1] & s1_cin);
        nxt_ovf  = (s1_amsb == s1_bmsb) && (nxt_sum[WIDTH-1] != s1_amsb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_pg    <= '0;
            s1_gg    <= '0;
            s1_cin   <= 1'b0;
            s1_amsb  <= 1'b0;
            s1_bmsb  <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_p     <= in_p;
                s1_g     <= in_g;
                s1_pg    <= in_pg;
                s1_gg    <= in_gg;
                s1_cin   <= bus.cin;
                s1_amsb  <= bus.a[WIDTH-1];
                s1_bmsb  <= bus.b[WIDTH-1];
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid_r <= 1'b1;
                sum_r       <= nxt_sum;
                cout_r      <= nxt_cout;
                ovf_r       <= nxt_ovf;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: vector table with latency checks, then
// back-to-back, backpressure and mid-flight reset sequences.
module tb_cla_pipe_adder;
    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[12];
    vec_t rv;

    cla_pipe_adder_if #(.WIDTH(W)) bus();

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
    endtask

    // Presents one operand pair and checks it appears exactly two cycles later.
    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(1'b1, v.a, v.b, v.cin);
        #1 chk($sformatf("v%0d in_ready", idx), bus.in_ready, 1);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0);
        chk($sformatf("v%0d out_valid_early", idx), bus.out_valid, 0);
        @(negedge clk);
        chk($sformatf("v%0d out_valid", idx), bus.out_valid, 1);
        chk($sformatf("v%0d sum", idx), bus.sum, v.sum);
        chk($sformatf("v%0d cout", idx), bus.cout, v.cout);
        chk($sformatf("v%0d ovf", idx), bus.ovf, v.ovf);
    endtask

    initial begin
        vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1]  = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[3]  = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
        vecs[4]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vecs[5]  = '{32'h0FFF_FFFF, 32'h0000_0000, 1'b1, 32'h1000_0000, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[8]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1};
        vecs[9]  = '{32'h000F_FFFF, 32'h0000_0000, 1'b1, 32'h0010_0000, 1'b0, 1'b0};
        vecs[10] = '{32'h89AB_CDEF, 32'h7654_3210, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[11] = '{32'h0000_0008, 32'h0000_0008, 1'b0, 32'h0000_0010, 1'b0, 1'b0};

        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        #2;
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst sum", bus.sum, 0);
        chk("rst cout", bus.cout, 0);
        chk("rst ovf", bus.ovf, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Back-to-back, in_valid held high for three cycles.
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'd1, 32'd2, 1'b0);
        #1 chk("b2b in_ready0", bus.in_ready, 1);
        @(negedge clk);
        drive(1'b1, 32'd3, 32'd4, 1'b1);
        #1 chk("b2b in_ready1", bus.in_ready, 1);
        @(negedge clk);
        chk("b2b out0 valid", bus.out_valid, 1);
        chk("b2b out0 sum", bus.sum, 32'd3);
        drive(1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
        #1 chk("b2b in_ready2", bus.in_ready, 1);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0);
        chk("b2b out1 valid", bus.out_valid, 1);
        chk("b2b out1 sum", bus.sum, 32'd8);
        @(negedge clk);
        chk("b2b out2 valid", bus.out_valid, 1);
        chk("b2b out2 sum", bus.sum, 32'h0000_0000);
        chk("b2b out2 cout", bus.cout, 1);
        chk("b2b out2 ovf", bus.ovf, 0);
        @(negedge clk);
        chk("b2b drained", bus.out_valid, 0);

        // Backpressure: two transactions, out_ready low for four cycles.
        @(negedge clk);
        drive(1'b1, 32'd10, 32'd20, 1'b0);
        #1 chk("bp in_ready0", bus.in_ready, 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h100, 32'h23, 1'b1);
        #1 chk("bp in_ready1", bus.in_ready, 1);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0);
        chk("bp hold valid c2", bus.out_valid, 1);
        chk("bp hold sum c2", bus.sum, 32'd30);
        #1 chk("bp in_ready c2", bus.in_ready, 0);
        for (int c = 3; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp hold valid c%0d", c), bus.out_valid, 1);
            chk($sformatf("bp hold sum c%0d", c), bus.sum, 32'd30);
            chk($sformatf("bp in_ready c%0d", c), bus.in_ready, 0);
        end
        @(negedge clk);
        chk("bp first valid", bus.out_valid, 1);
        chk("bp first sum", bus.sum, 32'd30);
        bus.out_ready = 1'b1;
        #1 chk("bp in_ready release", bus.in_ready, 1);
        @(negedge clk);
        chk("bp second valid", bus.out_valid, 1);
        chk("bp second sum", bus.sum, 32'h124);
        @(negedge clk);
        chk("bp no dup", bus.out_valid, 0);

        // Reset pulse with both stages occupied.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h8000_0001, 32'h8000_0001, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'd3, 32'd4, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0);
        chk("mr full valid", bus.out_valid, 1);
        chk("mr full sum", bus.sum, 32'd2);
        chk("mr full cout", bus.cout, 1);
        chk("mr full ovf", bus.ovf, 1);
        #1 chk("mr full in_ready", bus.in_ready, 0);
        #1 rst = 1'b1;
        #1;
        chk("mr out_valid", bus.out_valid, 0);
        chk("mr sum", bus.sum, 0);
        chk("mr cout", bus.cout, 0);
        chk("mr ovf", bus.ovf, 0);
        chk("mr in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mr no stale %0d", c), bus.out_valid, 0);
        end
        rv = '{32'd5, 32'd6, 1'b0, 32'd11, 1'b0, 1'b0};
        run_vec(100, rv);
        @(negedge clk);
        chk("mr final drained", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
